mat_mul_sched: RTL and testbench
================================

MAT_MUL_SCHED -- requirements
Module: mat_mul_sched

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension of the scheduled multiply unit; legal range N >= 2.
REQ-002 SHALL have localparam DEPTH = $clog2(N), meaning multiply-mode pipeline latency in cycles.
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, [2], meaning requester i has an operation pending.
REQ-006 SHALL have port req_mode, input, [2], meaning requester i's operation type: 0 multiply, 1 add.
REQ-007 SHALL have port req_ready, output, [2], meaning requester i's operation is accepted this cycle.
REQ-008 SHALL have port mm_sel, output, 1, meaning index of the requester whose operands the external mux presents to the multiply unit.
REQ-009 SHALL have ports mm_valid_in, mm_mode and mm_cen, output, 1 each, meaning drives of the multiply unit's valid_in, mode and cen.
REQ-010 SHALL have port rsp_valid, output, 1, meaning the unit's result is valid this cycle.
REQ-011 SHALL have port rsp_id, output, 1, meaning the requester owning the current result.
REQ-012 SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-013 SHALL have ports perf_busy, perf_ops and perf_drain, output, 32 each, meaning performance counters.

Function
REQ-014 SHALL issue an operation in a cycle iff req_valid[w] && req_ready[w], where w is the arbitration winner; an issue drives mm_valid_in=1, mm_sel=w and mm_mode=req_mode[w].
REQ-015 SHALL drive mm_valid_in=0 and mm_mode=0 in every non-issue cycle.
REQ-016 SHALL arbitrate round-robin with pointer ptr: the winner is ptr if req_valid[ptr], else the other requester; ptr becomes the winner's complement only on an issue.
REQ-017 SHALL assert at most one req_ready bit per cycle, and only for the winner.
REQ-018 SHALL track in-flight multiplies with counter inflight (0..DEPTH): +1 on a multiply issue, -1 on a multiply response handshake, both together leaving it unchanged.
REQ-019 SHALL implement FSM states: IDLE (inflight==0), MUL (inflight>0, winner multiply or none), DRAIN (inflight>0, winner add).
REQ-020 SHALL not issue an add in DRAIN, with req_ready=0, ptr frozen and the winner retained, moving to IDLE when inflight reaches 0.
REQ-021 SHALL, for a multiply issued in cycle t, assert rsp_valid with rsp_id=w in cycle t+DEPTH, provided mm_cen was 1 throughout.
REQ-022 SHALL carry tags through a DEPTH-entry {valid,id} shift register advanced exactly when mm_cen=1 and mm_mode=0.
REQ-023 SHALL, for an add, assert rsp_valid=1 and rsp_id=w combinationally in the issue cycle.
REQ-024 SHALL make add req_ready depend on rsp_ready, so that add issue and response handshake coincide.
REQ-025 SHALL drive mm_cen=0 iff the tag-pipe output is valid and rsp_ready=0, holding the unit, tag pipe and rsp outputs stable.
REQ-026 SHALL not issue any operation while mm_cen=0.
REQ-027 SHALL derive rsp_valid only from internal state, never from the unit's valid_out, because the unit's valid registers are unreset.
REQ-028 SHALL accept back-to-back multiplies at one per cycle (throughput 1).

Reset
REQ-029 SHALL, on rst=1 at a clk edge, clear state to IDLE, inflight, tag pipe and perf counters to 0, and ptr to 0.
REQ-030 SHALL, during reset, drive req_ready=0, mm_valid_in=0, mm_mode=0, mm_cen=1, mm_sel=0, rsp_valid=0 and rsp_id=0.
REQ-031 SHALL discard any in-flight operations when reset is applied mid-operation, with no response for them.

Configuration
REQ-032 SHALL, with macro MAT_MUL_SCHED_PERF_EN defined, run free-running wrapping counters: perf_busy counts cycles with inflight>0 or an issue, perf_ops counts issues, and perf_drain counts DRAIN cycles.
REQ-033 SHALL, without MAT_MUL_SCHED_PERF_EN, keep the perf_* ports and tie them to 0, with no counter logic.

Verification
REQ-034 SHALL cover: N=4, req0 multiply at t=10, rsp_ready=1 -> rsp_valid=1 and rsp_id=0 at t=12, with inflight back to 0.
REQ-035 SHALL cover: both requesters continuously requesting multiply -> grants alternate 0,1,0,1 and 4 responses arrive in order on 4 consecutive cycles.
REQ-036 SHALL cover: multiply from req0 then add from req1 next cycle, N=4 -> add stalls for 1 DRAIN cycle, mm_mode=1 only on the add issue cycle, and perf_drain=1.
REQ-037 SHALL cover: rsp_ready=0 for 3 cycles while a multiply result is valid -> mm_cen=0, rsp held unchanged, no issues, then resume without loss.
REQ-038 SHALL cover: rst asserted with 2 multiplies in flight -> rsp_valid never asserts for them and all outputs match REQ-030.
REQ-039 SHALL cover: add request with rsp_ready=0 -> req_ready=0 and no issue until rsp_ready=1.

Source files
------------

// File: rtl/mat_mul_sched_if.sv
// mat_mul_sched_if -- handshake bundle between requesters/consumer and the
// multiply-unit scheduler.
//
// Signals:
//   req_valid[1:0]  requester i has an operation pending
//   req_mode[1:0]   requester i operation type (0 multiply, 1 add)
//   req_ready[1:0]  requester i operation accepted this cycle
//   mm_sel          requester index presented to the multiply unit
//   mm_valid_in     multiply unit valid_in drive
//   mm_mode         multiply unit mode drive
//   mm_cen          multiply unit clock enable drive
//   rsp_valid       result valid this cycle
//   rsp_id          requester owning the current result
//   rsp_ready       consumer accepts the result
//   perf_busy/perf_ops/perf_drain  32-bit performance counters
//
// Modports: master = requester/consumer side, slave = scheduler side.
interface mat_mul_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_mode;
    logic [1:0]  req_ready;
    logic        mm_sel;
    logic        mm_valid_in;
    logic        mm_mode;
    logic        mm_cen;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_ready;
    logic [31:0] perf_busy;
    logic [31:0] perf_ops;
    logic [31:0] perf_drain;

    modport master (
        output req_valid, req_mode, rsp_ready,
        input  req_ready, mm_sel, mm_valid_in, mm_mode, mm_cen,
        input  rsp_valid, rsp_id, perf_busy, perf_ops, perf_drain
    );

    modport slave (
        input  req_valid, req_mode, rsp_ready,
        output req_ready, mm_sel, mm_valid_in, mm_mode, mm_cen,
        output rsp_valid, rsp_id, perf_busy, perf_ops, perf_drain
    );
endinterface

// File: rtl/mat_mul_sched.sv
// mat_mul_sched -- two-requester round-robin scheduler for a pipelined
// matrix multiply unit (multiply latency DEPTH = $clog2(N), add is
// combinational in the issue cycle).
//
// Ports:
//   clk   single clock
//   rst   synchronous active-high reset
//   bus   mat_mul_sched_if.slave (requests, unit drives, response, perf)
//
// Optional feature: define MAT_MUL_SCHED_PERF_EN to enable the free-running
// perf_busy / perf_ops / perf_drain counters; otherwise they read 0.
//
// Responses are generated purely from the internal tag pipe, never from the
// unit's own valid_out, because the unit's valid flops are not reset.
module mat_mul_sched #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    mat_mul_sched_if.slave bus
);
    localparam int DEPTH = $clog2(N);
    localparam int IW    = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] INF_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] INF_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q;
    logic             ptr_q;
    logic             drain_win_q;
    logic [IW-1:0]    inflight_q;
    logic [IW-1:0]    inflight_d;
    logic [DEPTH-1:0] tag_v_q;
    logic [DEPTH-1:0] tag_id_q;

    logic win_s;
    logic win_valid_s;
    logic win_mode_s;
    logic out_v_s;
    logic out_id_s;
    logic cen_s;
    logic mul_issue_s;
    logic add_issue_s;
    logic issue_s;
    logic mul_rsp_s;
    logic advance_s;

    // Arbitration, issue qualification and in-flight multiply accounting
    always_comb begin
        win_s = 1'b0;
        // While draining, the stalled add requester keeps the grant slot.
        if (state_q == DRAIN) begin
            win_s = drain_win_q;
        end else if (bus.req_valid[ptr_q]) begin
            win_s = ptr_q;
        end else begin
            win_s = ~ptr_q;
        end
        win_valid_s = bus.req_valid[win_s];
        win_mode_s  = bus.req_mode[win_s];

        out_v_s  = tag_v_q[DEPTH-1];
        out_id_s = tag_id_q[DEPTH-1];
        // Freeze everything while a finished multiply waits on the consumer.
        cen_s    = ~(out_v_s & ~bus.rsp_ready);

        mul_issue_s = ~rst & win_valid_s & ~win_mode_s & cen_s & (state_q != DRAIN);
        // An add answers in its issue cycle, so it needs an empty pipe and a
        // ready consumer to avoid colliding with a multiply response.
        add_issue_s = ~rst & win_valid_s & win_mode_s & cen_s & (state_q != DRAIN)
                    & (inflight_q == INF_ZERO) & bus.rsp_ready;
        issue_s     = mul_issue_s | add_issue_s;
        mul_rsp_s   = ~rst & out_v_s & bus.rsp_ready;
        advance_s   = cen_s & ~add_issue_s;

        case ({mul_issue_s, mul_rsp_s})
            2'b10:   inflight_d = inflight_q + INF_ONE;
            2'b01:   inflight_d = inflight_q - INF_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // Scheduler FSM: state, round-robin pointer, retained drain winner, inflight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            drain_win_q <= 1'b0;
            inflight_q  <= INF_ZERO;
        end else begin
            inflight_q <= inflight_d;
            if (issue_s) begin
                ptr_q <= ~win_s;
            end else begin
                ptr_q <= ptr_q;
            end
            case (state_q)
                IDLE, MUL: begin
                    if (inflight_d == INF_ZERO) begin
                        state_q <= IDLE;
                    end else if (win_valid_s && win_mode_s && !issue_s) begin
                        state_q     <= DRAIN;
                        drain_win_q <= win_s;
                    end else begin
                        state_q <= MUL;
                    end
                end
                DRAIN: begin
                    if (inflight_d == INF_ZERO) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag pipe mirroring the multiply unit; stage DEPTH-1 is the response
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q  <= {DEPTH{1'b0}};
            tag_id_q <= {DEPTH{1'b0}};
        end else if (advance_s) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            tag_v_q[0]  <= mul_issue_s;
            tag_id_q[0] <= win_s;
        end else begin
            tag_v_q  <= tag_v_q;
            tag_id_q <= tag_id_q;
        end
    end

    assign bus.req_ready[0] = issue_s & ~win_s;
    assign bus.req_ready[1] = issue_s & win_s;
    assign bus.mm_sel       = rst ? 1'b0 : win_s;
    assign bus.mm_valid_in  = issue_s;
    assign bus.mm_mode      = add_issue_s;
    assign bus.mm_cen       = rst ? 1'b1 : cen_s;
    assign bus.rsp_valid    = ~rst & (out_v_s | add_issue_s);
    assign bus.rsp_id       = rst ? 1'b0 : (add_issue_s ? win_s : out_id_s);

`ifdef MAT_MUL_SCHED_PERF_EN
    logic [31:0] busy_q;
    logic [31:0] ops_q;
    logic [31:0] drain_q;

    // Free-running wrapping performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 32'd0;
            ops_q   <= 32'd0;
            drain_q <= 32'd0;
        end else begin
            busy_q  <= busy_q + {31'd0, (inflight_q != INF_ZERO) | issue_s};
            ops_q   <= ops_q + {31'd0, issue_s};
            drain_q <= drain_q + {31'd0, state_q == DRAIN};
        end
    end

    assign bus.perf_busy  = busy_q;
    assign bus.perf_ops   = ops_q;
    assign bus.perf_drain = drain_q;
`else
    assign bus.perf_busy  = 32'd0;
    assign bus.perf_ops   = 32'd0;
    assign bus.perf_drain = 32'd0;
`endif
endmodule

// File: tb/tb_mat_mul_sched.sv
module tb_mat_mul_sched;
    localparam int N     = 4;
    localparam int DEPTH = $clog2(N);

    logic clk;
    logic rst;
    mat_mul_sched_if bus ();

    mat_mul_sched #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding multiplies as a queue of (owner, cycles
    // left until presentation); arbitration pointer; drain flag.
    typedef struct {
        bit id;
        int left;
    } ent_t;
    ent_t        q[$];
    bit          m_ptr   = 1'b0;
    bit          m_drain = 1'b0;
    bit          m_dwin  = 1'b0;
    int unsigned m_busy  = 0;
    int unsigned m_ops   = 0;
    int unsigned m_drn   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] md, input logic rr, input logic r);
        bit due, cen, w, wv, wm, mi, ai;
        int sz;
        logic [1:0] e_ready;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_mode  = md;
        bus.rsp_ready = rr;
        #1;
        sz  = q.size();
        due = (sz > 0) && (q[0].left == 0);
        cen = !(due && !rr);
        w   = m_drain ? m_dwin : (v[m_ptr] ? m_ptr : !m_ptr);
        wv  = v[w];
        wm  = md[w];
        mi  = !r && wv && !wm && cen && !m_drain;
        ai  = !r && wv && wm && cen && !m_drain && (sz == 0) && rr;
        if (r) begin
            chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
            chk("rst_mm_valid_in", {31'd0, bus.mm_valid_in}, 32'd0);
            chk("rst_mm_mode", {31'd0, bus.mm_mode}, 32'd0);
            chk("rst_mm_cen", {31'd0, bus.mm_cen}, 32'd1);
            chk("rst_mm_sel", {31'd0, bus.mm_sel}, 32'd0);
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        end else begin
            e_ready = (mi || ai) ? (w ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", {30'd0, bus.req_ready}, {30'd0, e_ready});
            chk("mm_valid_in", {31'd0, bus.mm_valid_in}, {31'd0, mi || ai});
            chk("mm_mode", {31'd0, bus.mm_mode}, {31'd0, ai});
            chk("mm_cen", {31'd0, bus.mm_cen}, {31'd0, cen});
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, due || ai});
            if (mi || ai) chk("mm_sel", {31'd0, bus.mm_sel}, {31'd0, w});
            if (ai) chk("rsp_id_add", {31'd0, bus.rsp_id}, {31'd0, w});
            else if (due) chk("rsp_id_mul", {31'd0, bus.rsp_id}, {31'd0, q[0].id});
`ifdef MAT_MUL_SCHED_PERF_EN
            chk("perf_busy", bus.perf_busy, m_busy);
            chk("perf_ops", bus.perf_ops, m_ops);
            chk("perf_drain", bus.perf_drain, m_drn);
`else
            chk("perf_busy", bus.perf_busy, 32'd0);
            chk("perf_ops", bus.perf_ops, 32'd0);
            chk("perf_drain", bus.perf_drain, 32'd0);
`endif
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ptr = 1'b0; m_drain = 1'b0; m_dwin = 1'b0;
            m_busy = 0; m_ops = 0; m_drn = 0;
        end else begin
            m_busy += ((sz > 0) || mi || ai) ? 1 : 0;
            m_ops  += (mi || ai) ? 1 : 0;
            m_drn  += m_drain ? 1 : 0;
            if (cen && !ai) begin
                if (due) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) q[i].left = q[i].left - 1;
            end
            if (mi) q.push_back('{id: w, left: DEPTH - 1});
            if (mi || ai) m_ptr = !w;
            if (q.size() == 0) m_drain = 1'b0;
            else if (!m_drain && wv && wm && !ai) begin
                m_drain = 1'b1;
                m_dwin  = w;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_mode  = 2'b00;
        bus.rsp_ready = 1'b0;

        // Reset with noisy inputs and a stalled consumer
        step(2'b11, 2'b01, 1'b0, 1'b1);
        step(2'b01, 2'b00, 1'b0, 1'b1);
        step(2'b10, 2'b10, 1'b1, 1'b1);

        // Single multiply from requester 0, response DEPTH cycles later
        step(2'b01, 2'b00, 1'b1, 1'b0);
        idle(4);

        // Both requesters stream multiplies: alternating grants, in-order responses
        for (int i = 0; i < 8; i++) step(2'b11, 2'b00, 1'b1, 1'b0);
        idle(4);

        // Multiply then add on the next cycle: add waits through a drain
        step(2'b01, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, 2'b10, 1'b1, 1'b0);
        idle(3);

        // Consumer stall for 3 cycles while a multiply result is pending
        step(2'b01, 2'b00, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b1, 1'b0);
        step(2'b11, 2'b00, 1'b1, 1'b0);
        idle(4);

        // Add with consumer not ready is held off until it becomes ready
        for (int i = 0; i < 3; i++) step(2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 2'b01, 1'b1, 1'b0);
        idle(2);

        // Reset with two multiplies in flight: no responses afterwards
        step(2'b01, 2'b00, 1'b1, 1'b0);
        step(2'b10, 2'b00, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        idle(4);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
